// File: rtl/universal_shift_register.sv
// Parametrised universal shift register with hold/load/shift/rotate/clear modes
// and an MSB-first serializer FSM that reports busy/done.
module universal_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("universal_shift_register: WIDTH must be in 2..64");
    end

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeLoad  = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeShr   = 3'b011;
    localparam logic [2:0] ModeRol   = 3'b100;
    localparam logic [2:0] ModeRor   = 3'b101;
    localparam logic [2:0] ModeClear = 3'b110;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_d;
    logic             busy_d;
    logic             done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q;
        busy_d  = busy;
        done_d  = done;
        if (en) begin
            case (state_q)
                StIdle: begin
                    done_d = 1'b0;
                    if (start) begin
                        q_d     = d;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = StShift;
                    end else begin
                        case (mode)
                            ModeLoad:  q_d = d;
                            ModeShl:   q_d = {q[WIDTH-2:0], sin};
                            ModeShr:   q_d = {sin, q[WIDTH-1:1]};
                            ModeRol:   q_d = {q[WIDTH-2:0], q[WIDTH-1]};
                            ModeRor:   q_d = {q[0], q[WIDTH-1:1]};
                            ModeClear: q_d = '0;
                            default:   q_d = q;
                        endcase
                    end
                end
                StShift: begin
                    q_d = {q[WIDTH-2:0], sin};
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
                default: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q       <= q_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Outgoing bit of the active direction; SHIFT always drains from the MSB.
    always_comb begin
        sout = 1'b0;
        if (state_q == StShift) begin
            sout = q[WIDTH-1];
        end else if (state_q == StIdle) begin
            case (mode)
                ModeShl, ModeRol: sout = q[WIDTH-1];
                ModeShr, ModeRor: sout = q[0];
                default:          sout = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register at WIDTH 8, 2 and 16 sharing one stimulus.
module tb_universal_shift_register;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  mode;
    logic [63:0] d;
    logic        sin;
    logic        start;

    logic [7:0]  q8;
    logic [1:0]  q2;
    logic [15:0] q16;
    logic        sout8, sout2, sout16;
    logic        busy8, busy2, busy16;
    logic        done8, done2, done16;

    universal_shift_register #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[7:0]), .sin(sin), .start(start),
        .q(q8), .sout(sout8), .busy(busy8), .done(done8)
    );

    universal_shift_register #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[1:0]), .sin(sin), .start(start),
        .q(q2), .sout(sout2), .busy(busy2), .done(done2)
    );

    universal_shift_register #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[15:0]), .sin(sin), .start(start),
        .q(q16), .sout(sout16), .busy(busy16), .done(done16)
    );

    typedef struct {
        int          id;
        logic [63:0] q;
        logic        sout;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    // Hand-computed register contents
    logic [7:0]  rot_tbl  [8] = '{8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07, 8'h0E, 8'h1C};
    logic [7:0]  ser_tbl  [8] = '{8'hD6, 8'hAC, 8'h58, 8'hB0, 8'h60, 8'hC0, 8'h80, 8'h00};
    logic [7:0]  ser2_tbl [8] = '{8'h9C, 8'h38, 8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};
    logic [15:0] rot16    [4] = '{16'h5C2A, 16'hC2A5, 16'h2A5C, 16'hA5C2};
    logic [7:0]  sout_seq  = 8'b11010110;
    logic [7:0]  sout_seq2 = 8'b10011100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int id, input logic [63:0] eq, input logic es, input logic eb,
                            input logic ed, input string name);
        exp_t e;
        e.id = id; e.q = eq; e.sout = es; e.busy = eb; e.done = ed; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic sample_now();
        ->sample_ev;
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic s, input logic st);
        en = e; mode = m; sin = s; start = st;
    endtask

    // Monitor: drains every pending expectation whenever outputs are sampled
    initial begin : monitor
        exp_t        e;
        logic [63:0] aq;
        logic        as, ab, ad;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0: begin aq = {56'd0, q8};  as = sout8;  ab = busy8;  ad = done8;  end
                    1: begin aq = {62'd0, q2};  as = sout2;  ab = busy2;  ad = done2;  end
                    default: begin aq = {48'd0, q16}; as = sout16; ab = busy16; ad = done16; end
                endcase
                checks++;
                if (aq !== e.q || as !== e.sout || ab !== e.busy || ad !== e.done) begin
                    errors++;
                    $display("FAIL %s (dut %0d): got q=%h sout=%b busy=%b done=%b, want q=%h sout=%b busy=%b done=%b",
                             e.name, e.id, aq, as, ab, ad, e.q, e.sout, e.busy, e.done);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] x16;
        rst_n = 1'b0;
        d = '0;
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        #12;
        push_exp(0, 0, 0, 0, 0, "reset_state");
        sample_now();

        // Clock edge while reset held must not update anything
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        d = 64'hD6;
        push_exp(0, 0, 0, 0, 0, "reset_held");
        tick();

        rst_n = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        push_exp(0, 8'hD6, 0, 0, 0, "load"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        push_exp(0, 8'hD6, 0, 0, 0, "hold"); tick();
        d = 64'h9C;
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        push_exp(0, 8'h9C, 0, 0, 0, "load2"); tick();
        drive(1'b1, 3'b010, 1'b1, 1'b0);
        push_exp(0, 8'h39, 0, 0, 0, "shl"); tick();
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        push_exp(0, 8'h1C, 0, 0, 0, "shr"); tick();
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_exp(0, rot_tbl[i], rot_tbl[i][7], 0, 0, "rotl"); tick();
        end
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        push_exp(0, 8'h0E, 0, 0, 0, "rotr1"); tick();
        push_exp(0, 8'h07, 1, 0, 0, "rotr2"); tick();
        drive(1'b1, 3'b111, 1'b1, 1'b0);
        push_exp(0, 8'h07, 0, 0, 0, "reserved"); tick();
        drive(1'b0, 3'b110, 1'b0, 1'b0);
        push_exp(0, 8'h07, 0, 0, 0, "en_low_hold"); tick();
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        push_exp(0, 8'h00, 0, 0, 0, "clear"); tick();

        // Serializer
        d = 64'hD6;
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        push_exp(0, ser_tbl[0], sout_seq[7], 1, 0, "ser_bit"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            push_exp(0, ser_tbl[k], sout_seq[7-k], 1, 0, "ser_bit"); tick();
        end
        push_exp(0, 8'h00, 0, 0, 1, "ser_done"); tick();
        d = 64'h9C;
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        push_exp(0, 8'h00, 0, 0, 0, "done_ignores_start"); tick();

        // Stall with en low after bit 2, plus start/clear pulses mid-SHIFT
        d = 64'hD6;
        push_exp(0, ser_tbl[0], sout_seq[7], 1, 0, "stall_bit"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k < 3; k++) begin
            push_exp(0, ser_tbl[k], sout_seq[7-k], 1, 0, "stall_bit"); tick();
        end
        drive(1'b0, 3'b110, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            push_exp(0, ser_tbl[2], sout_seq[5], 1, 0, "stall_hold"); tick();
        end
        drive(1'b1, 3'b110, 1'b0, 1'b1);
        push_exp(0, ser_tbl[3], sout_seq[4], 1, 0, "ignore_start_mode"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int k = 4; k < 8; k++) begin
            push_exp(0, ser_tbl[k], sout_seq[7-k], 1, 0, "stall_bit"); tick();
        end
        push_exp(0, 8'h00, 0, 0, 1, "stall_done"); tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        push_exp(0, 8'h00, 0, 0, 1, "done_held_en_low"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        push_exp(0, 8'h00, 0, 0, 0, "done_clears"); tick();

        // Async reset during SHIFT bit 4
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        push_exp(0, ser_tbl[0], sout_seq[7], 1, 0, "pre_reset_bit"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            push_exp(0, ser_tbl[k], sout_seq[7-k], 1, 0, "pre_reset_bit"); tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(0, 8'h00, 0, 0, 0, "async_reset"); sample_now();
        rst_n = 1'b1;
        d = 64'h9C;
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        push_exp(0, ser2_tbl[0], sout_seq2[7], 1, 0, "post_reset_bit"); tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            push_exp(0, ser2_tbl[k], sout_seq2[7-k], 1, 0, "post_reset_bit"); tick();
        end
        push_exp(0, 8'h00, 0, 0, 1, "post_reset_done"); tick();
        push_exp(0, 8'h00, 0, 0, 0, "post_reset_idle"); tick();

        // Width sweep: WIDTH=2 and WIDTH=16 together
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(1, 0, 0, 0, 0, "w2_reset");
        push_exp(2, 0, 0, 0, 0, "w16_reset");
        sample_now();
        rst_n = 1'b1;
        d = 64'hA5C2;
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        for (int e = 1; e <= 18; e++) begin
            if (e == 1)      push_exp(1, 2'b10, 1, 1, 0, "w2_ser");
            else if (e == 2) push_exp(1, 2'b00, 0, 1, 0, "w2_ser");
            else if (e == 3) push_exp(1, 2'b00, 0, 0, 1, "w2_done");
            else             push_exp(1, 2'b00, 0, 0, 0, "w2_idle");
            if (e <= 16) begin
                x16 = 16'hA5C2 << (e - 1);
                push_exp(2, x16, x16[15], 1, 0, "w16_ser");
            end else if (e == 17) begin
                push_exp(2, 16'h0000, 0, 0, 1, "w16_done");
            end else begin
                push_exp(2, 16'h0000, 0, 0, 0, "w16_idle");
            end
            tick();
            drive(1'b1, 3'b000, 1'b0, 1'b0);
        end

        drive(1'b1, 3'b001, 1'b0, 1'b0);
        push_exp(1, 2'b10, 0, 0, 0, "w2_load");
        push_exp(2, 16'hA5C2, 0, 0, 0, "w16_load");
        tick();
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k % 2 == 1) push_exp(1, 2'b01, 0, 0, 0, "w2_rotl");
            else            push_exp(1, 2'b10, 1, 0, 0, "w2_rotl");
            if (k % 4 == 0) push_exp(2, rot16[k/4-1], rot16[k/4-1][15], 0, 0, "w16_rotl");
            tick();
        end
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        push_exp(1, 0, 0, 0, 0, "w2_clear");
        push_exp(2, 0, 0, 0, 0, "w16_clear");
        tick();

        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
